// File: rtl/dependency_matrix_spec_if.sv
// Dispatch, wakeup, cancel, release and flush bundle for the issue-queue dependency matrix.
// The scheduler side drives through the master modport; the matrix uses the slave modport.
interface dependency_matrix_spec_if #(
    parameter int ENTRY_NUM          = 16,
    parameter int DISPATCH_WIDTH     = 2,
    parameter int SRC_NUM            = 2,
    parameter int WAKEUP_WIDTH       = 2,
    parameter int STORE_WAKEUP_WIDTH = 1
);
    localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

    logic                                              stall_i;
    logic [DISPATCH_WIDTH-1:0]                         dispatch_i;
    logic [DISPATCH_WIDTH-1:0][PTR_W-1:0]              dispatchPtr_i;
    logic [DISPATCH_WIDTH-1:0][SRC_NUM-1:0]            srcReady_i;
    logic [DISPATCH_WIDTH-1:0][SRC_NUM-1:0][PTR_W-1:0] srcPtr_i;
    logic [DISPATCH_WIDTH-1:0][ENTRY_NUM-1:0]          storeDepVector_i;
    logic [WAKEUP_WIDTH-1:0]                           wakeup_i;
    logic [WAKEUP_WIDTH-1:0]                           wakeupSpec_i;
    logic [WAKEUP_WIDTH-1:0][ENTRY_NUM-1:0]            wakeupDst_i;
    logic [STORE_WAKEUP_WIDTH-1:0]                     storeWakeup_i;
    logic [STORE_WAKEUP_WIDTH-1:0][ENTRY_NUM-1:0]      storeWakeupDst_i;
    logic [WAKEUP_WIDTH-1:0]                           cancel_i;
    logic [ENTRY_NUM-1:0]                              release_i;
    logic [ENTRY_NUM-1:0]                              flush_i;
    logic [ENTRY_NUM-1:0]                              opReady_o;

    modport master (
        output stall_i, dispatch_i, dispatchPtr_i, srcReady_i, srcPtr_i, storeDepVector_i,
        output wakeup_i, wakeupSpec_i, wakeupDst_i, storeWakeup_i, storeWakeupDst_i,
        output cancel_i, release_i, flush_i,
        input  opReady_o
    );

    modport slave (
        input  stall_i, dispatch_i, dispatchPtr_i, srcReady_i, srcPtr_i, storeDepVector_i,
        input  wakeup_i, wakeupSpec_i, wakeupDst_i, storeWakeup_i, storeWakeupDst_i,
        input  cancel_i, release_i, flush_i,
        output opReady_o
    );
endinterface

// File: rtl/dependency_matrix_spec.sv
// Producer/consumer dependency matrix: bit [i][j] means consumer i still waits on producer j.
// Define DEPENDENCY_MATRIX_SPEC_CANCEL_EN to add speculative-wakeup shadows with next-cycle cancel.
module dependency_matrix_spec #(
    parameter int ENTRY_NUM          = 16,
    parameter int DISPATCH_WIDTH     = 2,
    parameter int SRC_NUM            = 2,
    parameter int WAKEUP_WIDTH       = 2,
    parameter int STORE_WAKEUP_WIDTH = 1
) (
    input logic                     clk,
    input logic                     rst,
    dependency_matrix_spec_if.slave bus
);
    localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

    typedef logic [ENTRY_NUM-1:0] row_t;

    row_t [ENTRY_NUM-1:0]      matrix_q;
    row_t [ENTRY_NUM-1:0]      matrix_d;
    row_t [ENTRY_NUM-1:0]      view_cancel;
    row_t [ENTRY_NUM-1:0]      view;
    row_t                      row_valid_q;
    row_t                      row_valid_d;
    row_t                      wake_cols;
    row_t                      row_busy;
    row_t [DISPATCH_WIDTH-1:0] dispatch_row;

    // Union of every column cleared this cycle, shared by the view and the dispatch bypass.
    always_comb begin : wake_mask
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        wake_cols = '0;
        for (int w = 0; w < WAKEUP_WIDTH; w++) begin
            if (bus.wakeup_i[w]) begin
                wake_cols = wake_cols | bus.wakeupDst_i[w];
            end
        end
        for (int s = 0; s < STORE_WAKEUP_WIDTH; s++) begin
            if (bus.storeWakeup_i[s]) begin
                wake_cols = wake_cols | bus.storeWakeupDst_i[s];
            end
        end
    end

`ifdef DEPENDENCY_MATRIX_SPEC_CANCEL_EN
    row_t [WAKEUP_WIDTH-1:0]   spec_rows_q;
    row_t [WAKEUP_WIDTH-1:0]   spec_rows_d;
    row_t [WAKEUP_WIDTH-1:0]   spec_col_q;
    row_t [WAKEUP_WIDTH-1:0]   spec_col_d;
    logic [WAKEUP_WIDTH-1:0]   spec_valid_q;
    logic [WAKEUP_WIDTH-1:0]   spec_valid_d;

    // A cancel re-arms the bits the previous committed speculative wakeup cleared.
    always_comb begin : cancel_restore
        view_cancel = matrix_q;
        for (int w = 0; w < WAKEUP_WIDTH; w++) begin
            if (bus.cancel_i[w] && spec_valid_q[w]) begin
                for (int i = 0; i < ENTRY_NUM; i++) begin
                    if (spec_rows_q[w][i]) begin
                        view_cancel[i] = view_cancel[i] | spec_col_q[w];
                    end
                end
            end
        end
    end

    always_comb begin : shadow_next
        spec_rows_d  = spec_rows_q;
        spec_col_d   = spec_col_q;
        spec_valid_d = spec_valid_q;
        if (!bus.stall_i) begin
            for (int w = 0; w < WAKEUP_WIDTH; w++) begin
                spec_valid_d[w] = bus.wakeup_i[w] & bus.wakeupSpec_i[w];
                spec_col_d[w]   = bus.wakeupDst_i[w];
                for (int i = 0; i < ENTRY_NUM; i++) begin
                    spec_rows_d[w][i] = |(view_cancel[i] & bus.wakeupDst_i[w]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_rows_q  <= '0;
            spec_col_q   <= '0;
            spec_valid_q <= '0;
        end else begin
            spec_rows_q  <= spec_rows_d;
            spec_col_q   <= spec_col_d;
            spec_valid_q <= spec_valid_d;
        end
    end
`else
    // Every wakeup is final, so the speculation inputs carry no meaning here.
    logic unused_spec_inputs;
    assign unused_spec_inputs = ^{bus.cancel_i, bus.wakeupSpec_i};
    assign view_cancel        = matrix_q;
`endif

    // Wakeup clears producer columns; flush removes both the squashed rows and their columns.
    always_comb begin : flush_view
        view     = '0;
        row_busy = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            view[i]     = bus.flush_i[i] ? '0 : (view_cancel[i] & ~wake_cols & ~bus.flush_i);
            row_busy[i] = |view[i];
        end
    end

    assign bus.opReady_o = row_valid_q & ~row_busy & ~bus.flush_i;

    // Out-of-range source pointers (non-power-of-two queues) simply select no producer.
    always_comb begin : dispatch_rows
        dispatch_row = '0;
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            for (int s = 0; s < SRC_NUM; s++) begin
                for (int j = 0; j < ENTRY_NUM; j++) begin
                    if (!bus.srcReady_i[l][s] && (bus.srcPtr_i[l][s] == PTR_W'(j))) begin
                        dispatch_row[l][j] = 1'b1;
                    end
                end
            end
            dispatch_row[l] = (dispatch_row[l] | bus.storeDepVector_i[l])
                              & ~wake_cols & ~bus.flush_i;
        end
    end

    always_comb begin : commit
        matrix_d    = matrix_q;
        row_valid_d = row_valid_q;
        if (bus.stall_i) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                matrix_d[i] = bus.flush_i[i] ? '0 : (matrix_q[i] & ~bus.flush_i);
            end
            row_valid_d = row_valid_q & ~bus.flush_i;
        end else begin
            matrix_d    = view;
            row_valid_d = row_valid_q & ~bus.release_i;
            // Later lanes overwrite earlier ones, so the highest lane wins a shared pointer.
            for (int l = 0; l < DISPATCH_WIDTH; l++) begin
                for (int i = 0; i < ENTRY_NUM; i++) begin
                    if (bus.dispatch_i[l] && (bus.dispatchPtr_i[l] == PTR_W'(i))
                        && !bus.flush_i[i]) begin
                        matrix_d[i]    = dispatch_row[l];
                        row_valid_d[i] = 1'b1;
                    end
                end
            end
            row_valid_d = row_valid_d & ~bus.flush_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the matrix is plain flops, not a RAM, so it is cleared by reset like any register.
            matrix_q    <= '0;
            row_valid_q <= '0;
        end else begin
            // NOTE: non-blocking assignment keeps every register updating from pre-edge values.
            matrix_q    <= matrix_d;
            row_valid_q <= row_valid_d;
        end
    end
endmodule
